tms320c1x_host_bridge: RTL and testbench

- I/O-port bridge on the external bus of the TMS320C1X DSP core.
- Decodes the DSP's IN/OUT port cycles (A[2:0], DEN_N, WE_N) into word accesses to host-shared memory using a request/acknowledge handshake.
- Stalls the core through its EN input until each access completes.
- Gives the host CPU a control register that drives the DSP's RS_N and BIO_N, and returns a DSP "done" flag.

---
 rtl/tms320c1x_bridge_pkg.sv | 22 ++
 rtl/tms320c1x_host_bridge.sv | 163 ++++++++++++++++
 tb/tb_tms320c1x_host_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tms320c1x_bridge_pkg.sv
// Shared definitions for the TMS320C1X host bridge.
//   - I/O port numbers decoded from the core's A[2:0] during IN/OUT cycles
//   - bridge FSM state encoding
//   - bit positions inside the host control word
package tms320c1x_bridge_pkg;

    localparam logic [2:0] PORT_ADDR = 3'd0;  // shared-memory address register
    localparam logic [2:0] PORT_DATA = 3'd1;  // shared-memory data window
    localparam logic [2:0] PORT_STAT = 3'd3;  // DONE / BIO status

    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_RD   = 2'd1,
        BS_WR   = 2'd2,
        BS_HOLD = 2'd3
    } BrState_t;

    localparam int HC_RS_BIT       = 0;   // 1 = release DSP reset
    localparam int HC_BIO_BIT      = 1;   // 1 = drive BIO_N active (low)
    localparam int HC_DONE_CLR_BIT = 15;  // 1 = clear DONE

endpackage

// File: rtl/tms320c1x_host_bridge.sv
// I/O-port bridge between the TMS320C1X external bus and host-shared memory.
//
// Ports:
//   CLK, RST              system clock, synchronous active-high reset
//   DSP_CE_R              core rising-phase enable; arms strobe sampling in IDLE
//   DSP_A/DO/WE_N/DEN_N   core port-cycle bus (port number, write data, strobes)
//   DSP_DI                data returned to the core (0 when DEN_N is high)
//   DSP_EN                core enable; low stalls the core during port-1 accesses
//   DSP_RS_N, DSP_BIO_N   core reset and BIO pins, driven from the host register
//   MEM_*                 shared-memory request/acknowledge interface
//   HOST_WE/HOST_D/HOST_Q host control register write and status readback
//   DBG_STATE             current bridge FSM state
//
// Memory handshake: MEM_RD or MEM_WR is raised with MEM_ADDR/MEM_WDATA stable
// and held until the one-cycle MEM_ACK pulse; MEM_RDATA is sampled only in the
// ACK cycle. ACK seen while no request is outstanding is ignored.
module tms320c1x_host_bridge
    import tms320c1x_bridge_pkg::*;
#(
    parameter int MEM_AW  = 16,
    parameter bit AUTOINC = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DSP_CE_R,
    input  logic [2:0]        DSP_A,
    input  logic [15:0]       DSP_DO,
    input  logic              DSP_WE_N,
    input  logic              DSP_DEN_N,
    output logic [15:0]       DSP_DI,
    output logic              DSP_EN,
    output logic              DSP_RS_N,
    output logic              DSP_BIO_N,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic              MEM_RD,
    output logic              MEM_WR,
    input  logic [15:0]       MEM_RDATA,
    input  logic              MEM_ACK,
    input  logic              HOST_WE,
    input  logic [15:0]       HOST_D,
    output logic [15:0]       HOST_Q,
    output BrState_t          DBG_STATE
);

    BrState_t    state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] rd_data_q;
    logic        done_q, rs_q, bio_q;
    logic        ce_seen_q;   // CE_R observed since the FSM last returned to IDLE
    logic        abort_q;     // host put the DSP in reset during this memory cycle

    logic        is_wr, is_rd, accept, port1, in_req, mem_done, aborting;
    logic [15:0] reg_rdata;
    logic        unused_host_bits;

    // WE wins when both strobes are low.
    assign is_wr    = ~DSP_WE_N;
    assign is_rd    = DSP_WE_N & ~DSP_DEN_N;
    assign port1    = (DSP_A == PORT_DATA);
    assign accept   = (state_q == BS_IDLE) && (is_wr || is_rd) && (ce_seen_q || DSP_CE_R);
    assign in_req   = (state_q == BS_RD) || (state_q == BS_WR);
    assign mem_done = in_req && MEM_ACK;
    // Abort also covers a host reset write landing in the ACK cycle itself.
    assign aborting = abort_q || (HOST_WE && !HOST_D[HC_RS_BIT]);

    assign unused_host_bits = ^HOST_D[14:2];

    always_comb begin
        state_d = state_q;
        DSP_EN  = 1'b1;
        case (state_q)
            BS_IDLE: begin
                if (accept && port1) begin
                    DSP_EN  = 1'b0;
                    state_d = is_wr ? BS_WR : BS_RD;
                end
            end
            BS_RD, BS_WR: begin
                DSP_EN = 1'b0;
                if (MEM_ACK) state_d = aborting ? BS_IDLE : BS_HOLD;
            end
            BS_HOLD: begin
                // Wait for the core to drop both strobes so one long strobe
                // cannot start a second memory cycle.
                if (DSP_WE_N && DSP_DEN_N) state_d = BS_IDLE;
            end
            default: state_d = BS_IDLE;
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (DSP_A)
            PORT_ADDR: reg_rdata = addr_q;
            PORT_STAT: reg_rdata = {done_q, 14'b0, bio_q};
            default:   reg_rdata = '0;
        endcase
    end

    assign DSP_DI    = DSP_DEN_N ? 16'h0000 : (port1 ? rd_data_q : reg_rdata);
    assign MEM_RD    = (state_q == BS_RD);
    assign MEM_WR    = (state_q == BS_WR);
    assign DSP_RS_N  = rs_q;
    assign DSP_BIO_N = ~bio_q;
    assign HOST_Q    = {done_q, 13'b0, bio_q, rs_q};
    assign DBG_STATE = state_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= BS_IDLE;
            addr_q    <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            rs_q      <= 1'b0;
            bio_q     <= 1'b0;
            ce_seen_q <= 1'b0;
            abort_q   <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            state_q <= state_d;

            if (HOST_WE) begin
                rs_q  <= HOST_D[HC_RS_BIT];
                bio_q <= HOST_D[HC_BIO_BIT];
            end

            if (HOST_WE && HOST_D[HC_DONE_CLR_BIT])
                done_q <= 1'b0;
            else if (accept && is_wr && DSP_A == PORT_STAT)
                done_q <= DSP_DO[15];

            if (state_q != BS_IDLE && state_d == BS_IDLE)
                ce_seen_q <= 1'b0;
            else if (DSP_CE_R)
                ce_seen_q <= 1'b1;

            if (!in_req || mem_done)
                abort_q <= 1'b0;
            else if (HOST_WE && !HOST_D[HC_RS_BIT])
                abort_q <= 1'b1;

            if (accept && is_wr && DSP_A == PORT_ADDR)
                addr_q <= DSP_DO;
            else if (mem_done && AUTOINC)
                addr_q <= addr_q + 16'd1;

            if (accept && port1) begin
                MEM_ADDR <= addr_q[MEM_AW-1:0];
                if (is_wr) MEM_WDATA <= DSP_DO;
            end

            if (mem_done) begin
                if (aborting)
                    rd_data_q <= '0;
                else if (state_q == BS_RD)
                    rd_data_q <= MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_tms320c1x_host_bridge.sv
module tb_tms320c1x_host_bridge;
    import tms320c1x_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        dsp_ce_r = 1'b0;
    logic [2:0]  dsp_a = 3'd0;
    logic [15:0] dsp_do = 16'h0;
    logic        dsp_we_n = 1'b1;
    logic        dsp_den_n = 1'b1;
    logic [15:0] dsp_di;
    logic        dsp_en, dsp_rs_n, dsp_bio_n;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        mem_ack = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_d = 16'h0;
    logic [15:0] host_q;
    BrState_t    dbg_state;

    tms320c1x_host_bridge #(.MEM_AW(16), .AUTOINC(1'b1)) dut (
        .CLK(clk), .RST(rst), .DSP_CE_R(dsp_ce_r), .DSP_A(dsp_a), .DSP_DO(dsp_do),
        .DSP_WE_N(dsp_we_n), .DSP_DEN_N(dsp_den_n), .DSP_DI(dsp_di), .DSP_EN(dsp_en),
        .DSP_RS_N(dsp_rs_n), .DSP_BIO_N(dsp_bio_n), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_RDATA(mem_rdata),
        .MEM_ACK(mem_ack), .HOST_WE(host_we), .HOST_D(host_d), .HOST_Q(host_q),
        .DBG_STATE(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_addr = 16'h0;
    logic        m_done = 1'b0;
    logic        m_rs   = 1'b0;
    logic        m_bio  = 1'b0;
    logic [15:0] m_rd   = 16'h0;   // value the core must see on a completed port-1 read
    bit          chk_en = 1'b0;

    function automatic logic [15:0] model_port(input logic [2:0] p);
        if (p == 3'd0) return m_addr;
        if (p == 3'd3) return {m_done, 14'b0, m_bio};
        return 16'h0;
    endfunction

    // Expected memory transactions: {is_write, addr, wdata}
    logic [32:0] exp_q[$];

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && chk_en) begin
            check1("rs_n", dsp_rs_n, m_rs);
            check1("bio_n", dsp_bio_n, !m_bio);
            check16("host_q", host_q, {m_done, 13'b0, m_bio, m_rs});
            if (dsp_den_n)
                check16("di_idle", dsp_di, 16'h0);
            else if (dsp_a == 3'd1) begin
                if (dsp_en) check16("di_mem", dsp_di, m_rd);
            end else
                check16("di_reg", dsp_di, model_port(dsp_a));
        end
    end

    // ---------------- memory responder + scoreboard ----------------
    int          ack_lat = 1;
    logic [15:0] rdata_next = 16'h0;
    bit          stray_ack = 1'b0;

    initial begin
        int req_cnt;
        logic [32:0] e;
        req_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            if (rst) begin
                req_cnt = 0;
            end else if (stray_ack) begin
                mem_ack = 1'b1;
            end else if (mem_rd || mem_wr) begin
                req_cnt++;
                if (req_cnt == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_next;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: got wr=%b addr=%h expected no cycle", mem_wr, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check1("mem_kind", mem_wr, e[32]);
                        check16("mem_addr", mem_addr, e[31:16]);
                        if (e[32]) check16("mem_wdata", mem_wdata, e[15:0]);
                    end
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] d);
        host_we = 1'b1;
        host_d  = d;
        tick();
        host_we = 1'b0;
        m_rs  = d[0];
        m_bio = d[1];
        if (d[15]) m_done = 1'b0;
    endtask

    task automatic reg_access(input bit wr, input logic [2:0] port, input logic [15:0] d,
                              output logic [15:0] rv);
        dsp_a    = port;
        dsp_do   = d;
        dsp_ce_r = 1'b1;
        if (wr) dsp_we_n = 1'b0; else dsp_den_n = 1'b0;
        @(negedge clk);
        rv = dsp_di;
        check1("reg_no_stall", dsp_en, 1'b1);
        tick();
        dsp_we_n  = 1'b1;
        dsp_den_n = 1'b1;
        dsp_ce_r  = 1'b0;
        if (wr && port == 3'd0) m_addr = d;
        if (wr && port == 3'd3) m_done = d[15];
    endtask

    task automatic mem_access(input bit wr, input logic [15:0] d, input int lat,
                              input int hold_extra, input int exp_stall);
        int stalls, reqc;
        bit fin;
        ack_lat = lat;
        if (wr) exp_q.push_back({1'b1, m_addr, d});
        else begin
            exp_q.push_back({1'b0, m_addr, 16'h0});
            rdata_next = d;
            m_rd = d;
        end
        dsp_a    = 3'd1;
        dsp_do   = wr ? d : 16'h0;
        dsp_ce_r = 1'b1;
        if (wr) dsp_we_n = 1'b0; else dsp_den_n = 1'b0;
        stalls = 0; reqc = 0; fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) reqc++;
            if (dsp_en) fin = 1'b1; else stalls++;
            tick();
            dsp_ce_r = 1'b0;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL mem_timeout: got DSP_EN low for 60 cycles expected release");
        end
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) reqc++;
            check1("hold_en", dsp_en, 1'b1);
            tick();
        end
        dsp_we_n  = 1'b1;
        dsp_den_n = 1'b1;
        @(negedge clk);
        if (mem_rd || mem_wr) reqc++;
        tick();
        check_int("stall_cycles", stalls, exp_stall);
        check_int("req_cycles", reqc, lat);
        m_addr = m_addr + 16'd1;
    endtask

    task automatic model_reset();
        m_addr = 16'h0; m_done = 1'b0; m_rs = 1'b0; m_bio = 1'b0; m_rd = 16'h0;
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of sequence");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] rv;
        int rdc, c;
        bit fin;

        // Reset values
        tick(); tick();
        @(negedge clk);
        check16("rst_di", dsp_di, 16'h0);
        check1("rst_en", dsp_en, 1'b1);
        check1("rst_rs_n", dsp_rs_n, 1'b0);
        check1("rst_bio_n", dsp_bio_n, 1'b1);
        check1("rst_mem_rd", mem_rd, 1'b0);
        check1("rst_mem_wr", mem_wr, 1'b0);
        check16("rst_mem_addr", mem_addr, 16'h0);
        check16("rst_mem_wdata", mem_wdata, 16'h0);
        check16("rst_host_q", host_q, 16'h0);
        check_int("rst_state", int'(dbg_state), int'(BS_IDLE));
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Host releases DSP reset
        host_write(16'h0001);
        @(negedge clk);
        check16("host_q_release", host_q, 16'h0001);
        check1("rs_n_release", dsp_rs_n, 1'b1);
        check1("bio_n_release", dsp_bio_n, 1'b1);
        tick();

        // Port 0 = 0x1234, port 1 write 0xBEEF, ack after 3 cycles
        reg_access(1'b1, 3'd0, 16'h1234, rv);
        mem_access(1'b1, 16'hBEEF, 3, 0, 4);
        check16("wr_mem_addr", mem_addr, 16'h1234);
        check16("wr_mem_wdata", mem_wdata, 16'hBEEF);
        reg_access(1'b0, 3'd0, 16'h0, rv);
        check16("addr_after_wr", rv, 16'h1235);

        // Port 0 = 0xFFFF, port 1 read with immediate ack, address wraps
        reg_access(1'b1, 3'd0, 16'hFFFF, rv);
        mem_access(1'b0, 16'h5A5A, 1, 0, 2);
        reg_access(1'b0, 3'd0, 16'h0, rv);
        check16("addr_wrap", rv, 16'h0000);

        // DONE set by the core, cleared by the host
        reg_access(1'b1, 3'd3, 16'h8000, rv);
        @(negedge clk);
        check16("host_q_done", host_q, 16'h8001);
        tick();
        host_write(16'h8001);
        @(negedge clk);
        check16("host_q_done_clr", host_q, 16'h0001);
        check1("rs_n_kept", dsp_rs_n, 1'b1);
        tick();

        // BIO active, status port readback
        host_write(16'h0003);
        reg_access(1'b0, 3'd3, 16'h0, rv);
        check16("stat_bio", rv, 16'h0001);
        reg_access(1'b1, 3'd3, 16'h8000, rv);
        reg_access(1'b0, 3'd3, 16'h0, rv);
        check16("stat_done_bio", rv, 16'h8001);

        // Reserved ports
        reg_access(1'b1, 3'd2, 16'h5555, rv);
        reg_access(1'b0, 3'd2, 16'h0, rv);
        check16("port2_read", rv, 16'h0000);
        reg_access(1'b0, 3'd6, 16'h0, rv);
        check16("port6_read", rv, 16'h0000);
        reg_access(1'b0, 3'd0, 16'h0, rv);
        check16("addr_untouched", rv, 16'h0000);

        // DEN_N held low 4 cycles past completion: single request only
        mem_access(1'b0, 16'h1111, 2, 4, 3);

        // Stray ACK while idle
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        @(negedge clk);
        check_int("stray_state", int'(dbg_state), int'(BS_IDLE));
        check1("stray_rd", mem_rd, 1'b0);
        check1("stray_en", dsp_en, 1'b1);
        tick();

        // Host puts the DSP in reset during a read
        ack_lat = 4;
        exp_q.push_back({1'b0, m_addr, 16'h0});
        rdata_next = 16'hC3C3;
        m_rd = 16'h0;
        dsp_a = 3'd1;
        dsp_den_n = 1'b0;
        dsp_ce_r = 1'b1;
        tick();
        dsp_ce_r = 1'b0;
        host_we = 1'b1;
        host_d  = 16'h0000;
        rdc = 0; fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            @(negedge clk);
            if (mem_rd) rdc++; else fin = 1'b1;
            if (fin) begin
                check_int("abort_state", int'(dbg_state), int'(BS_IDLE));
                check16("abort_di", dsp_di, 16'h0000);
                check1("abort_rs_n", dsp_rs_n, 1'b0);
            end
            tick();
            if (i == 0) begin
                host_we = 1'b0;
                m_rs = 1'b0;
                m_bio = 1'b0;
            end
        end
        check_int("abort_rd_cycles", rdc, 4);
        c = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) c++;
            tick();
        end
        check_int("abort_no_retrigger", c, 0);
        dsp_den_n = 1'b1;
        tick();

        // RST during a memory write
        host_write(16'h0001);
        reg_access(1'b1, 3'd0, 16'h0040, rv);
        ack_lat = 30;
        exp_q.push_back({1'b1, m_addr, 16'h7777});
        dsp_a = 3'd1;
        dsp_do = 16'h7777;
        dsp_we_n = 1'b0;
        dsp_ce_r = 1'b1;
        tick();
        dsp_ce_r = 1'b0;
        tick();
        rst = 1'b1;
        dsp_we_n = 1'b1;
        model_reset();
        tick();
        @(negedge clk);
        check1("rst_mid_wr", mem_wr, 1'b0);
        check1("rst_mid_en", dsp_en, 1'b1);
        check1("rst_mid_rs_n", dsp_rs_n, 1'b0);
        check16("rst_mid_host_q", host_q, 16'h0000);
        check_int("rst_mid_state", int'(dbg_state), int'(BS_IDLE));
        tick();
        rst = 1'b0;
        reg_access(1'b0, 3'd0, 16'h0, rv);
        check16("rst_mid_addr", rv, 16'h0000);

        // Normal operation resumes
        host_write(16'h0001);
        reg_access(1'b1, 3'd0, 16'h00A0, rv);
        mem_access(1'b1, 16'h0F0F, 2, 0, 3);
        reg_access(1'b0, 3'd0, 16'h0, rv);
        check16("addr_after_resume", rv, 16'h00A1);
        check_int("exp_q_drained", exp_q.size(), 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
